// File: rtl/escalonador_gray_pkg.sv
// Shared types and helpers for the round-robin Gray-to-binary scheduler.
package escalonador_gray_pkg;

    localparam int unsigned GRAY_W = 8;

    typedef enum logic {
        StEmpty,
        StFull
    } out_state_e;

    // Index after idx in a ring of n requesters.
    function automatic int unsigned next_rr(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/gray_para_binario.sv
// 8-bit Gray-to-binary converter (purely combinational).
module gray_para_binario
    import escalonador_gray_pkg::*;
(
    input  logic [GRAY_W-1:0] gray,
    output logic [GRAY_W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at and above its position.
    always_comb begin
        bin = '0;
        for (int i = 0; i < GRAY_W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/escalonador_gray.sv
// Round-robin scheduler sharing one Gray converter among NUM_REQ requesters,
// with a single-entry valid/ready output register and a conversion counter.
module escalonador_gray
    import escalonador_gray_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [GRAY_W*NUM_REQ-1:0] req_gray,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [GRAY_W-1:0]         out_bin,
    output logic [ID_W-1:0]           out_id,
    output logic [CNT_W-1:0]          conv_count
);

    out_state_e           state_q;
    logic [ID_W-1:0]      ptr_q;
    logic                 can_accept;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [GRAY_W-1:0]    gray_sel;
    logic [GRAY_W-1:0]    bin_conv;
    logic                 accept;
    int unsigned          idx;

    assign can_accept = (state_q == StEmpty) || out_ready;
    assign out_valid  = (state_q == StFull);

    // First valid requester at or after ptr_q, wrapping; the mux follows the grant.
    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        gray_sel     = '0;
        idx          = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_valid && req_valid[idx]) begin
                grant_valid       = 1'b1;
                grant_idx         = ID_W'(idx);
                grant_onehot[idx] = 1'b1;
                gray_sel          = req_gray[idx*GRAY_W +: GRAY_W];
            end
        end
    end

    assign accept    = grant_valid && can_accept && !rst;
    assign req_ready = accept ? grant_onehot : '0;

    gray_para_binario u_conv (
        .gray (gray_sel),
        .bin  (bin_conv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            ptr_q      <= '0;
            out_bin    <= '0;
            out_id     <= '0;
            conv_count <= '0;
        end else if (accept) begin
            state_q    <= StFull;
            out_bin    <= bin_conv;
            out_id     <= grant_idx;
            ptr_q      <= ID_W'(next_rr(32'(grant_idx), NUM_REQ));
            conv_count <= conv_count + CNT_W'(1);
        end else if (state_q == StFull && out_ready) begin
            state_q <= StEmpty;
        end
    end

endmodule

// File: tb/tb_escalonador_gray.sv
// Directed, table-driven bench for escalonador_gray (NUM_REQ=4).
module tb_escalonador_gray;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'h0;
    logic [31:0] req_gray = 32'h0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_bin;
    logic [1:0]  out_id;
    logic [15:0] conv_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    escalonador_gray #(
        .NUM_REQ (4),
        .ID_W    (2),
        .CNT_W   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bin    (out_bin),
        .out_id     (out_id),
        .conv_count (conv_count)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] gray;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [7:0]  exp_bin;
        logic [1:0]  exp_id;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [7:0] b,
                           input logic [1:0] id, input logic [15:0] cnt);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_bin"}, 32'(out_bin), 32'(b));
        chk({tag, ".out_id"}, 32'(out_id), 32'(id));
        chk({tag, ".conv_count"}, 32'(conv_count), 32'(cnt));
    endtask

    initial begin
        // Four valid requesters: 00,01,C0,80 -> 00,01,80,FF; grants rotate from 0.
        vecs[0]  = '{4'hF, 32'h80C00100, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0, 16'd1};
        vecs[1]  = '{4'hF, 32'h80C00100, 1'b1, 4'b0010, 1'b1, 8'h01, 2'd1, 16'd2};
        vecs[2]  = '{4'hF, 32'h80C00100, 1'b1, 4'b0100, 1'b1, 8'h80, 2'd2, 16'd3};
        vecs[3]  = '{4'hF, 32'h80C00100, 1'b1, 4'b1000, 1'b1, 8'hFF, 2'd3, 16'd4};
        vecs[4]  = '{4'hF, 32'h80C00100, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0, 16'd5};
        // Only req 2 valid with FF -> AA.
        vecs[5]  = '{4'b0100, 32'h00FF0000, 1'b1, 4'b0100, 1'b1, 8'hAA, 2'd2, 16'd6};
        // ptr=3, only req 1 valid -> granted; leaves ptr=2.
        vecs[6]  = '{4'b0010, 32'h00000100, 1'b1, 4'b0010, 1'b1, 8'h01, 2'd1, 16'd7};
        // ptr=2, req 0 (03 -> 02) and req 1 valid -> 0 then 1.
        vecs[7]  = '{4'b0011, 32'h00000103, 1'b1, 4'b0001, 1'b1, 8'h02, 2'd0, 16'd8};
        vecs[8]  = '{4'b0011, 32'h00000103, 1'b1, 4'b0010, 1'b1, 8'h01, 2'd1, 16'd9};
        // Only req 3 valid -> immediate grant.
        vecs[9]  = '{4'b1000, 32'h80000000, 1'b1, 4'b1000, 1'b1, 8'hFF, 2'd3, 16'd10};
        // Drain with no request: out_valid drops, data held.
        vecs[10] = '{4'b0000, 32'h80000000, 1'b1, 4'b0000, 1'b0, 8'hFF, 2'd3, 16'd10};
        vecs[11] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'hFF, 2'd3, 16'd10};
        // Empty accepts even with out_ready low; ptr=0 -> req 2 wins among {2,3}.
        vecs[12] = '{4'b1100, 32'h80FF0000, 1'b0, 4'b0100, 1'b1, 8'hAA, 2'd2, 16'd11};

        // Reset held two cycles with all requesters valid.
        rst       = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst.req_ready", 32'(req_ready), 32'h0);
            step();
        end
        rst = 1'b0;
        #1;
        chk_out("rst", 1'b0, 8'h00, 2'd0, 16'd0);
        chk("rst.first_grant", 32'(req_ready), 32'b0001);

        for (int i = 0; i < 13; i++) begin
            req_valid = vecs[i].valid;
            req_gray  = vecs[i].gray;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d.req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_bin,
                    vecs[i].exp_id, vecs[i].exp_cnt);
        end

        // Backpressure: FULL with AA from req 2, ptr=3; req 1 waits.
        req_valid = 4'b0010;
        req_gray  = 32'h00000100;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.req_ready", 32'(req_ready), 32'h0);
            step();
            chk_out("bp", 1'b1, 8'hAA, 2'd2, 16'd11);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_acc.req_ready", 32'(req_ready), 32'b0010);
        step();
        chk_out("drain_acc", 1'b1, 8'h01, 2'd1, 16'd12);

        // Counter wrap: 65523 more accepts reach FFFF, the next one wraps.
        req_valid = 4'hF;
        req_gray  = 32'h80C00100;
        for (int i = 0; i < 65523; i++) begin
            step();
        end
        chk("wrap.pre", 32'(conv_count), 32'hFFFF);
        step();
        chk("wrap.zero", 32'(conv_count), 32'h0);
        chk("wrap.out_valid", 32'(out_valid), 32'h1);

        // Reset while FULL discards the held result.
        rst = 1'b1;
        #1;
        chk("midrst.req_ready", 32'(req_ready), 32'h0);
        step();
        chk_out("midrst", 1'b0, 8'h00, 2'd0, 16'd0);
        rst = 1'b0;
        #1;
        chk("midrst.first_grant", 32'(req_ready), 32'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
